// File: rtl/mips_pkg.sv
// Shared encodings for the MEM stage: access sizes, writeback error codes,
// FSM states and the alignment rule used by both the stage and its bench.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } wb_err_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // The reserved size never reaches memory, so it is folded into misalignment.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_ext_if.sv
// Data-memory request/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_ext_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-lane extraction with sign/zero extension.
module mem_lane_align
    import mips_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    function automatic logic [31:0] extend(input logic [31:0] v, input mem_size_e sz,
                                           input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = v[7:0];
        h = v[15:0];
        case (sz)
            SZ_BYTE: return uns ? {24'd0, v[7:0]}  : 32'(b);
            SZ_HALF: return uns ? {16'd0, v[15:0]} : 32'(h);
            default: return v;
        endcase
    endfunction

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << off;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign lane      = rdata >> {off, 3'b000};
    assign load_data = extend(lane, size, is_unsigned);

endmodule

// File: rtl/mem_stage_ext.sv
// MIPS MEM stage with a stalling request/ack data-memory port, alignment
// checking and a bounded wait that aborts hung accesses.
module mem_stage_ext
    import mips_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int REG_W    = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        wb_ctrl,
    input  logic              branch,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [31:0]       store_data,
    input  logic              zero,
    input  logic [REG_W-1:0]  write_reg,
    output logic              pc_src,
    output logic              stall,
    mem_stage_ext_if.master   dmem,
    output logic              wb_valid,
    output logic [1:0]        wb_ctrl_out,
    output logic [31:0]       wb_read_data,
    output logic [ADDR_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic [1:0]        wb_err
);

    state_e            state;
    logic [7:0]        wait_cnt;

    // Operation captured at acceptance, held for the whole BUSY phase
    logic              req_p1;
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [3:0]        be_p1;
    logic [31:0]       wdata_p1;
    logic              load_p1;
    mem_size_e         size_p1;
    logic [1:0]        off_p1;
    logic              uns_p1;
    logic [1:0]        wb_ctrl_p1;
    logic [ADDR_W-1:0] alu_p1;
    logic [REG_W-1:0]  reg_p1;

    logic              busy;
    logic              mem_op;
    logic              misaligned;
    logic              timeout;
    mem_size_e         lane_size;
    logic [1:0]        lane_off;
    logic              lane_uns;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_load;

    assign busy       = (state == ST_BUSY);
    assign mem_op     = mem_read | mem_write;
    assign misaligned = is_misaligned(mem_size_e'(mem_size), alu_result[1:0]);
    assign timeout    = busy && !dmem.dmem_ack && (wait_cnt == 8'(MAX_WAIT - 1));

    // In IDLE the lanes serve the incoming store; in BUSY they decode the load reply.
    assign lane_size  = busy ? size_p1 : mem_size_e'(mem_size);
    assign lane_off   = busy ? off_p1  : alu_result[1:0];
    assign lane_uns   = busy ? uns_p1  : mem_unsigned;

    mem_lane_align u_lane (
        .size        (lane_size),
        .off         (lane_off),
        .is_unsigned (lane_uns),
        .store_data  (store_data),
        .rdata       (dmem.dmem_rdata),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .load_data   (lane_load)
    );

    assign pc_src = reset && !busy && in_valid && branch && zero;
    assign stall  = reset && (busy ? (!dmem.dmem_ack && !timeout)
                                   : (in_valid && mem_op && !misaligned));

    assign dmem.dmem_req   = req_p1;
    assign dmem.dmem_we    = we_p1;
    assign dmem.dmem_addr  = addr_p1;
    assign dmem.dmem_be    = be_p1;
    assign dmem.dmem_wdata = wdata_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= 8'd0;
            req_p1        <= 1'b0;
            wb_valid      <= 1'b0;
            wb_ctrl_out   <= 2'd0;
            wb_read_data  <= 32'd0;
            wb_alu_result <= '0;
            wb_write_reg  <= '0;
            wb_err        <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    wb_valid <= 1'b0;
                    if (in_valid) begin
                        if (mem_op && !misaligned) begin
                            state      <= ST_BUSY;
                            wait_cnt   <= 8'd0;
                            req_p1     <= 1'b1;
                            we_p1      <= mem_write;
                            addr_p1    <= {alu_result[ADDR_W-1:2], 2'b00};
                            be_p1      <= lane_be;
                            wdata_p1   <= lane_wdata;
                            load_p1    <= mem_read;
                            size_p1    <= mem_size_e'(mem_size);
                            off_p1     <= alu_result[1:0];
                            uns_p1     <= mem_unsigned;
                            wb_ctrl_p1 <= wb_ctrl;
                            alu_p1     <= alu_result;
                            reg_p1     <= write_reg;
                        end else begin
                            wb_valid      <= 1'b1;
                            wb_ctrl_out   <= mem_op ? 2'd0 : wb_ctrl;
                            wb_read_data  <= 32'd0;
                            wb_alu_result <= alu_result;
                            wb_write_reg  <= write_reg;
                            wb_err        <= mem_op ? ERR_MISALIGN : ERR_NONE;
                        end
                    end
                end
                ST_BUSY: begin
                    if (dmem.dmem_ack) begin
                        state         <= ST_IDLE;
                        req_p1        <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_ctrl_out   <= wb_ctrl_p1;
                        wb_read_data  <= load_p1 ? lane_load : 32'd0;
                        wb_alu_result <= alu_p1;
                        wb_write_reg  <= reg_p1;
                        wb_err        <= ERR_NONE;
                    end else if (timeout) begin
                        state         <= ST_IDLE;
                        req_p1        <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_ctrl_out   <= 2'd0;
                        wb_read_data  <= 32'd0;
                        wb_alu_result <= alu_p1;
                        wb_write_reg  <= reg_p1;
                        wb_err        <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Directed bench for mem_stage_ext with a hand-driven memory responder.
module tb_mem_stage_ext;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  wb_ctrl;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        zero;
    logic [4:0]  write_reg;
    logic        pc_src;
    logic        stall;
    logic        wb_valid;
    logic [1:0]  wb_ctrl_out;
    logic [31:0] wb_read_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic [1:0]  wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          stalls, reqs, drift, done;
    logic [3:0]  be_o;
    logic [31:0] wd_o, ad_o;
    logic        we_o;

    mem_stage_ext_if #(.ADDR_W(32)) dif ();

    mem_stage_ext #(.ADDR_W(32), .REG_W(5), .MAX_WAIT(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .wb_ctrl       (wb_ctrl),
        .branch        (branch),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_size      (mem_size),
        .mem_unsigned  (mem_unsigned),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .zero          (zero),
        .write_reg     (write_reg),
        .pc_src        (pc_src),
        .stall         (stall),
        .dmem          (dif),
        .wb_valid      (wb_valid),
        .wb_ctrl_out   (wb_ctrl_out),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_write_reg  (wb_write_reg),
        .wb_err        (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        zero       = 1'b0;
        store_data = 32'h0;
        alu_result = 32'h0;
    endtask

    // Present one op in the current IDLE cycle, answer it with ack in BUSY
    // cycle ack_at (0 = never) and return once the MEM/WB slot has been written.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdat, input int ack_at, input logic [1:0] wbc);
        stalls = 0; reqs = 0; drift = 0; done = 0;
        be_o = 4'h0; wd_o = 32'h0; ad_o = 32'h0; we_o = 1'b0;
        in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_unsigned = uns; alu_result = addr; store_data = sd;
        wb_ctrl = wbc; write_reg = 5'd7;
        #1;
        if (stall) stalls++;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
                store_data = ~sd; alu_result = 32'hFFFF_FFFC;
            end
            if (!dif.dmem_req) begin
                dif.dmem_ack = 1'b0;
                done = 1;
                break;
            end
            if (c == 1) begin
                be_o = dif.dmem_be; wd_o = dif.dmem_wdata;
                ad_o = dif.dmem_addr; we_o = dif.dmem_we;
            end else if (dif.dmem_be !== be_o || dif.dmem_wdata !== wd_o ||
                         dif.dmem_addr !== ad_o || dif.dmem_we !== we_o) begin
                drift++;
            end
            reqs++;
            dif.dmem_rdata = rdat;
            dif.dmem_ack   = (c == ack_at);
            #1;
            if (stall) stalls++;
        end
        dif.dmem_ack = 1'b0;
        check_eq("op_done", 32'(done), 32'd1);
    endtask

    task automatic check_wb(input string t, input logic [1:0] err, input logic [1:0] ctrl,
                            input logic [31:0] rdata, input logic [31:0] alu,
                            input int exp_reqs, input int exp_stalls);
        check_eq({t, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check_eq({t, "_wb_err"},   32'(wb_err), 32'(err));
        check_eq({t, "_wb_ctrl"},  32'(wb_ctrl_out), 32'(ctrl));
        check_eq({t, "_rdata"},    wb_read_data, rdata);
        check_eq({t, "_alu"},      wb_alu_result, alu);
        check_eq({t, "_wreg"},     32'(wb_write_reg), 32'd7);
        check_eq({t, "_reqs"},     32'(reqs), 32'(exp_reqs));
        check_eq({t, "_stalls"},   32'(stalls), 32'(exp_stalls));
    endtask

    task automatic check_bus(input string t, input logic we, input logic [3:0] be,
                             input logic [31:0] wd, input logic [31:0] ad);
        check_eq({t, "_we"},    32'(we_o), 32'(we));
        check_eq({t, "_be"},    32'(be_o), 32'(be));
        check_eq({t, "_wdata"}, wd_o, wd);
        check_eq({t, "_addr"},  ad_o, ad);
        check_eq({t, "_drift"}, 32'(drift), 32'd0);
    endtask

    initial begin
        dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;
        wb_ctrl = 2'd0; write_reg = 5'd0; mem_size = SZ_WORD; mem_unsigned = 1'b0;
        clear_inputs();

        // Reset held with a live load and a taken branch on the inputs
        reset = 1'b0;
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 32'h10; branch = 1'b1; zero = 1'b1;
        tick(); tick();
        check_eq("rst_pc_src", 32'(pc_src), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_req", 32'(dif.dmem_req), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_wb_err", 32'(wb_err), 32'd0);
        check_eq("rst_wb_ctrl", 32'(wb_ctrl_out), 32'd0);
        check_eq("rst_rdata", wb_read_data, 32'd0);
        clear_inputs();
        reset = 1'b1;
        tick();

        run_op(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 3, 2'b01);
        check_bus("sw", 1'b1, 4'b1111, 32'hDEADBEEF, 32'h10);
        check_wb("sw", ERR_NONE, 2'b01, 32'h0, 32'h10, 3, 3);
        tick();
        check_eq("sw_pulse_end", 32'(wb_valid), 32'd0);

        run_op(1, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h80FF_1234, 1, 2'b11);
        check_bus("lb", 1'b0, 4'b1000, 32'h0, 32'h10);
        check_wb("lb", ERR_NONE, 2'b11, 32'hFFFF_FF80, 32'h13, 1, 1);

        run_op(1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h80FF_1234, 1, 2'b11);
        check_wb("lbu", ERR_NONE, 2'b11, 32'h0000_0080, 32'h13, 1, 1);

        run_op(1, 0, SZ_HALF, 0, 32'h22, 32'h0, 32'h80FF_1234, 1, 2'b11);
        check_bus("lh_hi", 1'b0, 4'b1100, 32'h0, 32'h20);
        check_wb("lh_hi", ERR_NONE, 2'b11, 32'hFFFF_80FF, 32'h22, 1, 1);

        run_op(1, 0, SZ_HALF, 1, 32'h20, 32'h0, 32'h80FF_9234, 1, 2'b11);
        check_bus("lhu_lo", 1'b0, 4'b0011, 32'h0, 32'h20);
        check_wb("lhu_lo", ERR_NONE, 2'b11, 32'h0000_9234, 32'h20, 1, 1);

        run_op(0, 1, SZ_BYTE, 0, 32'h11, 32'h0000_00A5, 32'h0, 1, 2'b00);
        check_bus("sb", 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h10);

        run_op(0, 1, SZ_HALF, 0, 32'h22, 32'h1234_BEEF, 32'h0, 2, 2'b00);
        check_bus("sh", 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h20);
        check_wb("sh", ERR_NONE, 2'b00, 32'h0, 32'h22, 2, 2);

        run_op(1, 0, SZ_HALF, 0, 32'h21, 32'h0, 32'h0, 1, 2'b11);
        check_wb("lh_mis", ERR_MISALIGN, 2'b00, 32'h0, 32'h21, 0, 0);

        run_op(1, 0, SZ_RSVD, 0, 32'h20, 32'h0, 32'h0, 1, 2'b11);
        check_wb("rsvd_size", ERR_MISALIGN, 2'b00, 32'h0, 32'h20, 0, 0);

        run_op(0, 1, SZ_WORD, 0, 32'h12, 32'h0, 32'h0, 1, 2'b01);
        check_wb("sw_mis", ERR_MISALIGN, 2'b00, 32'h0, 32'h12, 0, 0);

        run_op(1, 0, SZ_WORD, 0, 32'h30, 32'h0, 32'hCAFE_F00D, 0, 2'b11);
        check_wb("timeout", ERR_TIMEOUT, 2'b00, 32'h0, 32'h30, 4, 4);

        run_op(1, 0, SZ_WORD, 0, 32'h30, 32'h0, 32'hCAFE_F00D, 4, 2'b11);
        check_wb("ack_last", ERR_NONE, 2'b11, 32'hCAFE_F00D, 32'h30, 4, 4);

        run_op(0, 0, SZ_WORD, 0, 32'h1234, 32'h0, 32'h0, 1, 2'b10);
        check_wb("alu_op", ERR_NONE, 2'b10, 32'h0, 32'h1234, 0, 0);

        // Branch in IDLE, then the same inputs while BUSY, then reset mid-BUSY
        in_valid = 1'b1; branch = 1'b1; zero = 1'b0;
        #1;
        check_eq("br_not_taken", 32'(pc_src), 32'd0);
        zero = 1'b1; mem_read = 1'b1; mem_size = SZ_WORD; alu_result = 32'h40;
        #1;
        check_eq("br_idle", 32'(pc_src), 32'd1);
        check_eq("busy_accept_stall", 32'(stall), 32'd1);
        tick();
        check_eq("busy_req", 32'(dif.dmem_req), 32'd1);
        check_eq("br_busy", 32'(pc_src), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_busy_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b1;
        clear_inputs();
        dif.dmem_ack = 1'b1;
        #1;
        check_eq("rst_busy_req", 32'(dif.dmem_req), 32'd0);
        check_eq("rst_busy_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        dif.dmem_ack = 1'b0;
        check_eq("late_ack_req", 32'(dif.dmem_req), 32'd0);
        check_eq("late_ack_wb_valid", 32'(wb_valid), 32'd0);
        in_valid = 1'b1; branch = 1'b1; zero = 1'b1;
        #1;
        check_eq("idle_after_rst", 32'(pc_src), 32'd1);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_ext.md
MEM_STAGE_EXT -- requirements
Module: mem_stage_ext

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, data-memory address width; REG_W, default 5, register-index width; MAX_WAIT, default 15, maximum cycles to wait for dmem_ack (range 1..255). Data width SHALL be fixed at 32.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
clk  in  1  single clock; every flop SHALL update on the rising edge
reset  in  1  reset, synchronous, active-low
in_valid  in  1  EX/MEM slot holds a live instruction
wb_ctrl  in  2  RegWrite/MemtoReg, carried through unchanged
branch  in  1  branch instruction
mem_read  in  1  load
mem_write  in  1  store
mem_size  in  2  access size: 0=byte, 1=half, 2=word, 3=reserved
mem_unsigned  in  1  load is zero-extended when 1, sign-extended when 0
alu_result  in  ADDR_W  effective address / ALU result
store_data  in  32  store operand (rt)
zero  in  1  ALU zero flag
write_reg  in  REG_W  destination register
pc_src  out  1  branch taken
stall  out  1  hold EX/MEM and all earlier stages
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-aligned store data
dmem_rdata  in  32  read data, valid with ack
dmem_ack  in  1  access complete
wb_valid  out  1  MEM/WB slot live
wb_ctrl_out  out  2  registered wb_ctrl (forced 0 on error)
wb_read_data  out  32  extended load data
wb_alu_result  out  ADDR_W  registered alu_result
wb_write_reg  out  REG_W  registered write_reg
wb_err  out  2  0=none, 1=misaligned, 2=timeout

Function
REQ-003 pc_src SHALL equal in_valid & branch & zero while state is IDLE, else 0 (combinational).
REQ-004 FSM states SHALL be IDLE and BUSY.
REQ-005 IDLE, in_valid, neither mem_read nor mem_write: next edge SHALL load the MEM/WB outputs with wb_valid=1, wb_read_data=0, wb_err=0; stall=0.
REQ-006 IDLE, in_valid, mem op, aligned: stall=1; next edge SHALL capture the operation and enter BUSY with dmem_req=1 and wb_valid=0.
REQ-007 Alignment: half requires addr[0]=0; word requires addr[1:0]=0; mem_size=3 SHALL be treated as misaligned. A misaligned op SHALL issue no request, stall=0, and complete in one cycle with wb_err=1 and wb_ctrl_out=0.
REQ-008 Byte enables: byte SHALL give 4'b0001<<addr[1:0]; half SHALL give 4'b0011 or 4'b1100 per addr[1]; word SHALL give 4'b1111. Store data SHALL be replicated across lanes (byte x4, half x2).
REQ-009 Loads SHALL select the addressed lane of dmem_rdata and extend per mem_unsigned.
REQ-010 BUSY: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata SHALL stay constant; inputs SHALL be ignored; stall SHALL equal !dmem_ack.
REQ-011 BUSY with dmem_ack: next edge SHALL write MEM/WB (wb_valid=1, wb_err=0), drop dmem_req and return to IDLE; the completion cycle SHALL be 2 cycles after acceptance when ack is immediate.
REQ-012 Wait counter SHALL clear on entry to BUSY and increment per un-acked BUSY cycle; at count==MAX_WAIT without ack, the op SHALL abort: dmem_req dropped, stall=0, wb_valid=1, wb_err=2, wb_ctrl_out=0, return to IDLE.
REQ-013 Ack arriving in the same cycle the counter reaches MAX_WAIT SHALL win (normal completion).
REQ-014 in_valid=0 in IDLE SHALL yield wb_valid=0 at the next edge.
REQ-015 dmem_ack in IDLE SHALL be ignored.

Reset
REQ-016 When reset=0 at a rising edge: state=IDLE, counter=0, dmem_req=0, wb_valid=0, and all wb_* outputs 0, including mid-BUSY (the in-flight op is dropped).
REQ-017 pc_src and stall SHALL be 0 while reset=0.

Structure
REQ-018 mem_size encodings, wb_err codes and FSM state encoding SHALL be defined in the shared package mips_pkg.
REQ-019 Lane steering (byte enables, store replication, load extraction) SHALL be a combinational sub-module mem_lane_align.

Verification
REQ-020 Word store, addr 0x10, data 0xDEADBEEF, ack after 3 cycles -> be=4'b1111, wdata=0xDEADBEEF, stall high for 3 cycles, wb_valid pulse, wb_err=0.
REQ-021 Signed byte load, addr 0x13, rdata 0x80FF_1234, immediate ack -> wb_read_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 Half load, addr 0x21 -> no dmem_req, wb_err=1, wb_ctrl_out=0, stall never high.
REQ-023 MAX_WAIT=4, ack withheld -> dmem_req high 4 cycles, then wb_err=2; ack on the 4th cycle -> normal completion.
REQ-024 Branch with zero=1 in IDLE -> pc_src=1 same cycle; same inputs while BUSY -> pc_src=0.
REQ-025 reset=0 during BUSY -> next cycle dmem_req=0, wb_valid=0, state IDLE; a late ack SHALL have no effect.
